// File: rtl/car_motion_fsm.sv
// Per-car SCAN motion sequencer: walks the car floor by floor and times travel and doors.
// Optional CAR_DOOR_HOLD_EN adds a door_hold input that keeps the door open while high.
module car_motion_fsm #(
  parameter int N_FLOORS    = 10,
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef CAR_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  input  logic [9:0] queue,
  output logic [5:0] state_word,
  output logic [9:0] served,
  output logic       door_open,
  output logic       moving
);

  localparam int QW   = 10;
  localparam int MAXT = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;

  function automatic logic [QW-1:0] valid_mask();
    logic [QW-1:0] m;
    m = '0;
    for (int i = 0; i < QW; i++) m[i] = (i < N_FLOORS);
    return m;
  endfunction

  function automatic logic req_above(input logic [QW-1:0] m, input logic [3:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < QW; i++) if (m[i] && (4'(i) > f)) r = 1'b1;
    return r;
  endfunction

  function automatic logic req_below(input logic [QW-1:0] m, input logic [3:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < QW; i++) if (m[i] && (4'(i) < f)) r = 1'b1;
    return r;
  endfunction

  function automatic logic req_here(input logic [QW-1:0] m, input logic [3:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < QW; i++) if (4'(i) == f) r = m[i];
    return r;
  endfunction

  function automatic logic [QW-1:0] onehot(input logic [3:0] f);
    logic [QW-1:0] r;
    for (int i = 0; i < QW; i++) r[i] = (4'(i) == f);
    return r;
  endfunction

  state_t          state_q;
  logic [3:0]      floor_q;
  logic            dir_q;
  logic            busy_q;
  logic            door_q;
  logic            moving_q;
  logic [QW-1:0]   served_q;
  logic [TW-1:0]   timer_q;

  logic [QW-1:0]   q_m;
  logic [3:0]      floor_d;
  logic            hold;
  logic            here_c, above_c, below_c, ahead_c, behind_c;
  logic            here_nx, above_nx, below_nx, ahead_nx, behind_nx;

`ifdef CAR_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  assign q_m     = queue & valid_mask();
  assign floor_d = dir_q ? (floor_q + 4'd1) : (floor_q - 4'd1);

  assign here_c   = req_here(q_m, floor_q);
  assign above_c  = req_above(q_m, floor_q);
  assign below_c  = req_below(q_m, floor_q);
  assign ahead_c  = dir_q ? above_c : below_c;
  assign behind_c = dir_q ? below_c : above_c;

  // Decisions taken on arrival use the floor the car is about to reach.
  assign here_nx   = req_here(q_m, floor_d);
  assign above_nx  = req_above(q_m, floor_d);
  assign below_nx  = req_below(q_m, floor_d);
  assign ahead_nx  = dir_q ? above_nx : below_nx;
  assign behind_nx = dir_q ? below_nx : above_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      floor_q  <= 4'd0;
      dir_q    <= 1'b1;
      busy_q   <= 1'b0;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
      served_q <= '0;
      timer_q  <= '0;
    end else begin
      served_q <= '0;
      case (state_q)
        S_IDLE: begin
          timer_q <= '0;
          if (here_c) begin
            state_q  <= S_DOOR;
            busy_q   <= 1'b1;
            door_q   <= 1'b1;
            served_q <= onehot(floor_q);
          end else if (above_c) begin
            state_q  <= S_UP;
            dir_q    <= 1'b1;
            busy_q   <= 1'b1;
            moving_q <= 1'b1;
          end else if (below_c) begin
            state_q  <= S_DOWN;
            dir_q    <= 1'b0;
            busy_q   <= 1'b1;
            moving_q <= 1'b1;
          end
        end

        S_UP, S_DOWN: begin
          if (timer_q == FLOOR_LAST) begin
            timer_q <= '0;
            floor_q <= floor_d;
            if (here_nx) begin
              state_q  <= S_DOOR;
              moving_q <= 1'b0;
              door_q   <= 1'b1;
              served_q <= onehot(floor_d);
            end else if (ahead_nx) begin
              state_q <= state_q;
            end else if (behind_nx) begin
              state_q <= dir_q ? S_DOWN : S_UP;
              dir_q   <= ~dir_q;
            end else begin
              state_q  <= S_IDLE;
              busy_q   <= 1'b0;
              moving_q <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        S_DOOR: begin
          // The request register clears one cycle after served, so skip the cycle right after a pulse.
          if (here_c && (served_q == '0)) begin
            served_q <= onehot(floor_q);
            timer_q  <= '0;
          end else if (hold) begin
            timer_q <= '0;
          end else if (timer_q == DOOR_LAST) begin
            timer_q <= '0;
            door_q  <= 1'b0;
            if (ahead_c) begin
              state_q  <= dir_q ? S_UP : S_DOWN;
              moving_q <= 1'b1;
            end else if (behind_c) begin
              state_q  <= dir_q ? S_DOWN : S_UP;
              dir_q    <= ~dir_q;
              moving_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state_word = {floor_q, dir_q, busy_q};
  assign served     = served_q;
  assign door_open  = door_q;
  assign moving     = moving_q;

endmodule

// File: tb/tb_car_motion_fsm.sv
// Bench for car_motion_fsm with FLOOR_TICKS=4, DOOR_TICKS=6: vector table plus multi-cycle scenarios.
// Build with CAR_DOOR_HOLD_EN defined to exercise the door_hold input.
module tb_car_motion_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] queue = '0;
`ifdef CAR_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif
  logic [5:0] state_word;
  logic [9:0] served;
  logic       door_open;
  logic       moving;

  always #5 clk = ~clk;

  car_motion_fsm #(.N_FLOORS(10), .FLOOR_TICKS(4), .DOOR_TICKS(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CAR_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .queue(queue),
    .state_word(state_word),
    .served(served),
    .door_open(door_open),
    .moving(moving)
  );

  typedef struct packed {
    logic [5:0] sw;
    logic [9:0] sv;
    logic       door;
    logic       mov;
  } obs_t;

  typedef struct packed {
    logic       rst_n;
    logic [9:0] q;
    obs_t       exp;
  } vec_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_t;

  int   total = 0;
  int   bad = 0;
  int   overlap = 0;
  sb_t  sbq[$];
  int   served_log[$];
  logic dir_log[$];
  int   door_cycles;
  int   move_cycles;

  always @(negedge clk) if ((door_open || served != '0) && moving) overlap++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // The request register clears a bit once the car reports it served.
  task automatic tick();
    @(posedge clk);
    #1;
    queue = queue & ~served;
  endtask

  function automatic obs_t cur();
    return {state_word, served, door_open, moving};
  endfunction

  function automatic int idx(input logic [9:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 10; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic sb_push(input string name, input obs_t exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_pop_check();
    sb_t e;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check(e.name, 32'(cur()), 32'(e.exp));
    end
  endtask

  task automatic wait_floor(input logic [3:0] f, input int lim, input string name);
    int n;
    n = 0;
    while (state_word[5:2] != f && n < lim) begin
      tick();
      n++;
    end
    check(name, 32'(state_word[5:2]), 32'(f));
  endtask

  task automatic run_idle(input int lim, input string name);
    int n;
    n = 0;
    served_log.delete();
    dir_log.delete();
    door_cycles = 0;
    move_cycles = 0;
    do begin
      tick();
      n++;
      if (served != '0) begin
        served_log.push_back(idx(served));
        dir_log.push_back(state_word[1]);
      end
      if (door_open) door_cycles++;
      if (moving) move_cycles++;
    end while (state_word[0] && n < lim);
    check({name, "_idle"}, 32'(state_word[0]), 32'd0);
  endtask

  function automatic vec_t mk(input logic r, input logic [9:0] q, input logic [5:0] sw,
                              input logic [9:0] sv, input logic d, input logic m);
    vec_t v;
    v.rst_n = r;
    v.q     = q;
    v.exp   = {sw, sv, d, m};
    return v;
  endfunction

  vec_t vt[18];
  int   hold_door;

  initial begin
    vt[0]  = mk(1'b0, 10'h000, 6'b000010, 10'h000, 1'b0, 1'b0);
    vt[1]  = mk(1'b1, 10'h000, 6'b000010, 10'h000, 1'b0, 1'b0);
    vt[2]  = mk(1'b1, 10'h001, 6'b000011, 10'h001, 1'b1, 1'b0);
    vt[3]  = mk(1'b1, 10'h000, 6'b000011, 10'h000, 1'b1, 1'b0);
    vt[4]  = mk(1'b1, 10'h000, 6'b000011, 10'h000, 1'b1, 1'b0);
    vt[5]  = mk(1'b1, 10'h000, 6'b000011, 10'h000, 1'b1, 1'b0);
    vt[6]  = mk(1'b1, 10'h000, 6'b000011, 10'h000, 1'b1, 1'b0);
    vt[7]  = mk(1'b1, 10'h000, 6'b000011, 10'h000, 1'b1, 1'b0);
    vt[8]  = mk(1'b1, 10'h000, 6'b000010, 10'h000, 1'b0, 1'b0);
    vt[9]  = mk(1'b1, 10'h002, 6'b000011, 10'h000, 1'b0, 1'b1);
    vt[10] = mk(1'b1, 10'h002, 6'b000011, 10'h000, 1'b0, 1'b1);
    vt[11] = mk(1'b1, 10'h002, 6'b000011, 10'h000, 1'b0, 1'b1);
    vt[12] = mk(1'b1, 10'h002, 6'b000011, 10'h000, 1'b0, 1'b1);
    vt[13] = mk(1'b1, 10'h002, 6'b000111, 10'h002, 1'b1, 1'b0);
    vt[14] = mk(1'b1, 10'h000, 6'b000111, 10'h000, 1'b1, 1'b0);
    vt[15] = mk(1'b0, 10'h000, 6'b000010, 10'h000, 1'b0, 1'b0);
    vt[16] = mk(1'b1, 10'h004, 6'b000011, 10'h000, 1'b0, 1'b1);
    vt[17] = mk(1'b0, 10'h004, 6'b000010, 10'h000, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      rst_n = vt[i].rst_n;
      queue = vt[i].q;
      sb_push($sformatf("vec%0d", i), vt[i].exp);
      tick();
      sb_pop_check();
    end

    // Floor 0 to floor 3: 12 moving cycles, one served pulse, 6 door cycles.
    rst_n = 1'b1;
    queue = 10'h008;
    run_idle(100, "to3");
    check("to3_move_cycles", 32'(move_cycles), 32'd12);
    check("to3_door_cycles", 32'(door_cycles), 32'd6);
    check("to3_serve_count", 32'(served_log.size()), 32'd1);
    if (served_log.size() > 0) check("to3_serve_floor", 32'(served_log[0]), 32'd3);
    check("to3_final_word", 32'(state_word), 32'(6'b001110));

    // Request at the current floor opens the door on the next cycle.
    queue = 10'h010;
    run_idle(100, "to4");
    queue = 10'h010;
    sb_push("here_opens", {6'b010011, 10'h010, 1'b1, 1'b0});
    tick();
    sb_pop_check();
    run_idle(100, "here_close");

    // Heading up to 8, a request at 2 raised at floor 6 is served only after 8.
    queue = 10'h020;
    run_idle(100, "to5");
    queue = 10'h100;
    wait_floor(4'd6, 40, "reach6");
    queue = queue | 10'h004;
    run_idle(300, "scan");
    check("scan_serve_count", 32'(served_log.size()), 32'd2);
    if (served_log.size() == 2) begin
      check("scan_first", 32'(served_log[0]), 32'd8);
      check("scan_second", 32'(served_log[1]), 32'd2);
      check("scan_dir_at2", 32'(dir_log[1]), 32'd0);
    end
    check("scan_final_word", 32'(state_word), 32'(6'b001000));

    // At floor 5 with dir down, requests above and below together: up wins.
    queue = 10'h040;
    run_idle(100, "to6");
    queue = 10'h020;
    run_idle(100, "back5");
    check("back5_dir", 32'(state_word[1]), 32'd0);
    queue = 10'h104;
    sb_push("up_wins", {6'b010111, 10'h000, 1'b0, 1'b1});
    tick();
    sb_pop_check();
    run_idle(300, "both");
    check("both_serve_count", 32'(served_log.size()), 32'd2);
    if (served_log.size() == 2) begin
      check("both_first", 32'(served_log[0]), 32'd8);
      check("both_second", 32'(served_log[1]), 32'd2);
    end

    // Re-request while the door is open restarts the door timer.
    queue = 10'h004;
    tick();
    tick();
    tick();
    queue = 10'h004;
    run_idle(100, "repulse");
    check("repulse_serves", 32'(served_log.size()), 32'd1);
    check("repulse_door_cycles", 32'(door_cycles), 32'd6);

    // Door hold keeps the door open; without the feature the door lasts 6 cycles.
    queue = 10'h004;
    tick();
    hold_door = door_open ? 1 : 0;
`ifdef CAR_DOOR_HOLD_EN
    door_hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (door_open) hold_door++;
    end
    door_hold = 1'b0;
    run_idle(100, "hold");
    check("hold_door_cycles", 32'(hold_door + door_cycles), 32'd26);
`else
    run_idle(100, "nohold");
    check("nohold_door_cycles", 32'(hold_door + door_cycles), 32'd6);
`endif

    // Reset in the middle of an upward step at floor 5.
    queue = 10'h200;
    wait_floor(4'd5, 60, "reach5_up");
    tick();
    check("midstep_moving", 32'(moving), 32'd1);
    rst_n = 1'b0;
    sb_push("reset_midup", {6'b000010, 10'h000, 1'b0, 1'b0});
    tick();
    sb_pop_check();
    rst_n = 1'b1;
    queue = '0;
    sb_push("after_reset", {6'b000010, 10'h000, 1'b0, 1'b0});
    tick();
    sb_pop_check();

    check("no_door_while_moving", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
